pn_token_tx: RTL
================

Name: pn_token_tx

Overview:
- Transmit side of the Polish-Notation token interface. Buffers a host-loaded frame of up to 12 tokens and replays it, one token per cycle, onto the evaluator's mode/operator/in/in_valid inputs.
- Then collects the evaluator's out_valid/out results into a readable result buffer.
- Sits between the test/host controller and the PN evaluator; it is also used as the stimulus engine in system-level benches.

Parameters:
- MAX_TOK, 12, token buffer depth (frame length limit)
- MAX_RES, 4, result buffer depth
- TIMEOUT_CYC, 64, idle cycles allowed in WAIT before abort

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ld_valid  in  1  write one token into buffer (accepted in IDLE only)
- ld_op  in  1  token is operator (1) or operand (0)
- ld_val  in  3  operand value or opcode (0 add, 1 sub, 2 mul, 3 abs-add)
- ld_full  out  1  buffer holds MAX_TOK tokens
- start  in  1  begin transmission of buffered frame
- start_mode  in  2  mode sent with frame
- clr  in  1  empty buffer, return DONE->IDLE
- busy  out  1  high in SEND or WAIT
- pn_in_valid  out  1  token strobe to evaluator
- pn_mode  out  2  frame mode, held for whole frame, 0 otherwise
- pn_operator  out  1  token type
- pn_in  out  3  token value
- pn_out_valid  in  1  result strobe from evaluator
- pn_out  in  32  signed result
- done  out  1  high while in DONE
- timeout  out  1  WAIT aborted; valid while done
- res_cnt  out  3  results captured
- res_idx  in  2  result read address
- res_data  out  32  result[res_idx], combinational read

Behaviour:
- Reset: every output 0, tok_cnt=0, res_cnt=0, state IDLE. Async assertion forces pn_in_valid=0 immediately, including mid-SEND; the frame is discarded.
- FSM states: IDLE, SEND, WAIT, DONE. All pn_* outputs are registered.
- IDLE:
  - ld_valid with tok_cnt<MAX_TOK writes the token at tok_cnt and increments tok_cnt; ld_valid while full is dropped.
  - start with tok_cnt>0 latches start_mode, computes exp_cnt (modes 0/1: tok_cnt/3 floored, capped at MAX_RES; modes 2/3: 1), clears res_cnt and timeout, goes to SEND.
  - start with tok_cnt=0 is ignored. ld_valid and start in the same cycle: the load is taken, start is ignored.
- SEND:
  - Start sampled at cycle t gives first pn_in_valid at t+1.
  - pn_in_valid is high for exactly tok_cnt contiguous cycles, never gapped (the evaluator ends reception on the first low cycle).
  - Tokens go out in load order (index 0 first). pn_out_valid is ignored here.
  - After the last token: WAIT if exp_cnt>0, else DONE.
- WAIT:
  - Each pn_out_valid stores pn_out at res_cnt and increments it; the idle counter resets.
  - res_cnt reaching exp_cnt goes to DONE; further pn_out_valid is ignored.
  - TIMEOUT_CYC consecutive cycles with no pn_out_valid sets timeout=1 and goes to DONE with the partial res_cnt.
- DONE:
  - done=1; results stay readable.
  - start replays the same buffer (same rules as IDLE). clr sets tok_cnt=0 and goes to IDLE. start and clr together: clr wins.
  - clr in IDLE empties the buffer; clr in SEND/WAIT is ignored.
- The buffer is not consumed by sending; only clr or rst empties it.
- res_data for res_idx>=res_cnt returns the stale stored value (0 after reset).

Optional Feature:
- Macro PN_TX_STATS_EN.
- Defined: adds outputs frm_cnt[15:0] (frames completed without timeout) and to_cnt[15:0] (timeouts). Both saturate at 0xFFFF and are cleared only by rst.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Package pn_pkg holds:
  - state enum
  - opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_ABS=3
  - token struct {op, val[2:0]}
  - MAX_TOK/MAX_RES defaults
  - mode constants PRE_SORT_DN=0, POST_SORT_UP=1, PRE_STACK=2, POST_STACK=3
- One sub-module, pn_tok_buf: MAX_TOK-entry write-in-order / read-by-index token store with count and full flag. The FSM and result capture stay in the top.

Test Plan:
- Load (0,3),(0,4),(1,0), start mode 3: pn_in_valid high 3 cycles starting t+1, pn_mode=3 throughout. Bench returns 7 after 4 cycles: done=1, res_cnt=1, res_data[0]=7, timeout=0.
- Load 6 tokens (+,2,7),(-,1,2), start mode 0: exp_cnt=2. Bench returns 9 then -1: res_cnt=2, res_data[1]=0xFFFFFFFF. A third pn_out_valid (5) is not stored.
- Mode 2 frame with silent bench: timeout=1 and done=1 exactly TIMEOUT_CYC=64 cycles after the last token, res_cnt=0.
- 13 ld_valid pulses: ld_full after the 12th, 13th dropped. Start gives exactly 12 pn_in_valid cycles.
- rst asserted during the 4th token of SEND: pn_in_valid=0 the same cycle, busy=0, ld_full=0. Start after release is ignored (buffer empty).
- Load 2 tokens, start mode 1: exp_cnt=0, DONE one cycle after the 2nd token, no WAIT. Then start+clr together: IDLE, tok_cnt=0.

Source files
------------

// File: rtl/pn_pkg.sv
// rtl/pn_pkg.sv - shared types and constants for the PN token transmit path
package pn_pkg;

  localparam int MAX_TOK_DEF = 12;
  localparam int MAX_RES_DEF = 4;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_DONE} state_e;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_ABS = 3'd3;

  localparam logic [1:0] PRE_SORT_DN  = 2'd0;
  localparam logic [1:0] POST_SORT_UP = 2'd1;
  localparam logic [1:0] PRE_STACK    = 2'd2;
  localparam logic [1:0] POST_STACK   = 2'd3;

  typedef struct packed {
    logic       op;
    logic [2:0] val;
  } token_t;

  // Sort modes yield one result per operator triple; stack modes yield a single result.
  function automatic logic [2:0] calc_exp(logic [1:0] mode, int tok_cnt, int max_res);
    int n;
    if (mode == PRE_STACK || mode == POST_STACK) begin
      n = 1;
    end else begin
      n = tok_cnt / 3;
      if (n > max_res) n = max_res;
    end
    return n[2:0];
  endfunction

endpackage

// File: rtl/pn_tok_buf.sv
// rtl/pn_tok_buf.sv - in-order write, indexed read token store with count and full flag
module pn_tok_buf
  import pn_pkg::*;
#(
  parameter  int MAX_TOK = MAX_TOK_DEF,
  localparam int CW      = $clog2(MAX_TOK + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_i,
  input  token_t        wr_tok_i,
  input  logic          clr_i,
  input  logic [CW-1:0] rd_idx_i,
  output token_t        rd_tok_o,
  output logic [CW-1:0] cnt_o,
  output logic          full_o
);

  token_t        mem_q [MAX_TOK];
  logic [CW-1:0] cnt_q;

  assign full_o   = (cnt_q == CW'(MAX_TOK));
  assign cnt_o    = cnt_q;
  assign rd_tok_o = mem_q[rd_idx_i];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (wr_i && !full_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_i && !full_o && !clr_i) mem_q[cnt_q] <= wr_tok_i;
  end

endmodule

// File: rtl/pn_token_tx.sv
// rtl/pn_token_tx.sv - replays a buffered PN token frame to the evaluator and captures results
// Optional PN_TX_STATS_EN adds saturating frm_cnt/to_cnt outputs.
module pn_token_tx
  import pn_pkg::*;
#(
  parameter int MAX_TOK     = MAX_TOK_DEF,
  parameter int MAX_RES     = MAX_RES_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  input  logic        ld_op,
  input  logic [2:0]  ld_val,
  output logic        ld_full,
  input  logic        start,
  input  logic [1:0]  start_mode,
  input  logic        clr,
  output logic        busy,
  output logic        pn_in_valid,
  output logic [1:0]  pn_mode,
  output logic        pn_operator,
  output logic [2:0]  pn_in,
  input  logic        pn_out_valid,
  input  logic [31:0] pn_out,
  output logic        done,
  output logic        timeout,
  output logic [2:0]  res_cnt,
  input  logic [1:0]  res_idx,
`ifdef PN_TX_STATS_EN
  output logic [15:0] frm_cnt,
  output logic [15:0] to_cnt,
`endif
  output logic [31:0] res_data
);

  localparam int CW = $clog2(MAX_TOK + 1);
  localparam int RW = $clog2(MAX_RES);
  localparam int IW = $clog2(TIMEOUT_CYC);

  state_e        state_q;
  logic [CW-1:0] snd_idx_q;
  logic [2:0]    exp_q, res_cnt_q;
  logic [IW-1:0] idle_q;
  logic          timeout_q, pn_in_valid_q, pn_operator_q;
  logic [1:0]    pn_mode_q;
  logic [2:0]    pn_in_q;
  logic [31:0]   res_mem_q [MAX_RES];

  token_t        ld_tok, rd_tok;
  logic [CW-1:0] tok_cnt, rd_idx;
  logic          buf_wr, buf_clr, buf_full, can_start;
  logic          send_last, wait_hit, wait_to;

  assign ld_tok    = '{op: ld_op, val: ld_val};
  assign buf_wr    = (state_q == ST_IDLE) && ld_valid && !clr;
  assign buf_clr   = clr && (state_q == ST_IDLE || state_q == ST_DONE);
  assign rd_idx    = (state_q == ST_SEND) ? snd_idx_q : '0;
  // A load in the same cycle takes precedence over start, and clr beats both.
  assign can_start = start && !clr && !buf_wr && (tok_cnt != '0);
  assign send_last = (state_q == ST_SEND) && (snd_idx_q == tok_cnt);
  assign wait_hit  = (state_q == ST_WAIT) && pn_out_valid && (res_cnt_q + 3'd1 == exp_q);
  assign wait_to   = (state_q == ST_WAIT) && !pn_out_valid && (idle_q == IW'(TIMEOUT_CYC - 1));

  pn_tok_buf #(.MAX_TOK(MAX_TOK)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_i     (buf_wr),
    .wr_tok_i (ld_tok),
    .clr_i    (buf_clr),
    .rd_idx_i (rd_idx),
    .rd_tok_o (rd_tok),
    .cnt_o    (tok_cnt),
    .full_o   (buf_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      snd_idx_q     <= '0;
      exp_q         <= '0;
      res_cnt_q     <= '0;
      idle_q        <= '0;
      timeout_q     <= 1'b0;
      pn_in_valid_q <= 1'b0;
      pn_mode_q     <= '0;
      pn_operator_q <= 1'b0;
      pn_in_q       <= '0;
      for (int i = 0; i < MAX_RES; i++) res_mem_q[i] <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (can_start) begin
            state_q       <= ST_SEND;
            pn_mode_q     <= start_mode;
            exp_q         <= calc_exp(start_mode, 32'(tok_cnt), MAX_RES);
            res_cnt_q     <= '0;
            timeout_q     <= 1'b0;
            pn_in_valid_q <= 1'b1;
            pn_operator_q <= rd_tok.op;
            pn_in_q       <= rd_tok.val;
            snd_idx_q     <= CW'(1);
          end else if (clr) begin
            state_q   <= ST_IDLE;
            timeout_q <= 1'b0;
          end
        end
        ST_SEND: begin
          if (send_last) begin
            pn_in_valid_q <= 1'b0;
            pn_mode_q     <= '0;
            pn_operator_q <= 1'b0;
            pn_in_q       <= '0;
            idle_q        <= '0;
            state_q       <= (exp_q != '0) ? ST_WAIT : ST_DONE;
          end else begin
            pn_operator_q <= rd_tok.op;
            pn_in_q       <= rd_tok.val;
            snd_idx_q     <= snd_idx_q + 1'b1;
          end
        end
        ST_WAIT: begin
          if (pn_out_valid) begin
            res_mem_q[res_cnt_q[RW-1:0]] <= pn_out;
            res_cnt_q <= res_cnt_q + 3'd1;
            idle_q    <= '0;
            if (wait_hit) state_q <= ST_DONE;
          end else if (wait_to) begin
            timeout_q <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            idle_q <= idle_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign ld_full     = buf_full;
  assign busy        = (state_q == ST_SEND) || (state_q == ST_WAIT);
  assign done        = (state_q == ST_DONE);
  assign timeout     = timeout_q;
  assign res_cnt     = res_cnt_q;
  assign res_data    = res_mem_q[res_idx];
  assign pn_in_valid = pn_in_valid_q;
  assign pn_mode     = pn_mode_q;
  assign pn_operator = pn_operator_q;
  assign pn_in       = pn_in_q;

`ifdef PN_TX_STATS_EN
  logic [15:0] frm_cnt_q, to_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      if (((send_last && exp_q == '0) || wait_hit) && frm_cnt_q != 16'hFFFF)
        frm_cnt_q <= frm_cnt_q + 16'd1;
      if (wait_to && to_cnt_q != 16'hFFFF)
        to_cnt_q <= to_cnt_q + 16'd1;
    end
  end

  assign frm_cnt = frm_cnt_q;
  assign to_cnt  = to_cnt_q;
`endif

endmodule
